// File: rtl/haar_dwt2d_stream.sv
// haar_dwt2d_stream: streaming single-level 2-D Haar transform.
// Pixels arrive in raster order. Even rows are reduced horizontally into a
// line buffer of (L,H) pairs. Odd rows combine each new (L,H) pair with the
// buffered pair from the row above to produce one LL/LH/HL/HH set per 2x2 block.
// Optional build macro: HAAR_NORM_EN (floor-divide every coefficient by 4).
module haar_dwt2d_stream #(
  parameter int IMG_W  = 20,
  parameter int IMG_H  = 30,
  parameter int DATA_W = 8,
  parameter int CH     = 3,
  parameter int OUT_W  = DATA_W + 3
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [CH*DATA_W-1:0]  s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CH*OUT_W-1:0]   m_ll,
  output logic [CH*OUT_W-1:0]   m_lh,
  output logic [CH*OUT_W-1:0]   m_hl,
  output logic [CH*OUT_W-1:0]   m_hh,
  output logic                  m_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic [1:0]            dbg_state
);

  // Handshake: a beat transfers on a rising edge where valid && ready.
  // A source holds valid and data stable until that edge; ready may depend
  // combinationally on the sink's own state but never on valid.

  localparam int HW    = DATA_W + 1;
  localparam int LBW   = CH * 2 * HW;
  localparam int NPAIR = IMG_W / 2;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EVEN  = 2'd1;
  localparam logic [1:0] S_ODD   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]           state;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [CH*DATA_W-1:0] a_reg;
  logic [LBW-1:0]       lb [NPAIR];
  logic [LBW-1:0]       lb_rdata;
  logic [LBW-1:0]       lb_wdata;
  logic [PW-1:0]        pair_idx;
  logic [CH*OUT_W-1:0]  ll_n, lh_n, hl_n, hh_n;

  logic in_rows, accept, col_end, row_end, odd_col, load, out_take;

  assign in_rows  = (state == S_EVEN) || (state == S_ODD);
  assign s_ready  = in_rows && (!m_valid || m_ready);
  assign accept   = s_valid && s_ready;
  assign col_end  = (col == COL_LAST);
  assign row_end  = (row == ROW_LAST);
  assign odd_col  = col[0];
  assign pair_idx = PW'(col >> 1);
  assign load     = accept && odd_col && (state == S_ODD);
  assign out_take = m_valid && m_ready;
  assign busy     = (state != S_IDLE);
  assign dbg_state = state;
  assign lb_rdata = lb[pair_idx];

  // Frame sequencing: even row, odd row, repeat; flush waits for the last set.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_EVEN;
        S_EVEN:  if (accept && col_end) state <= S_ODD;
        S_ODD:   if (accept && col_end) state <= row_end ? S_FLUSH : S_EVEN;
        S_FLUSH: if (out_take && m_last) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Raster position of the next pixel; cleared when a frame starts.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      col <= '0;
      row <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        col <= '0;
        row <= '0;
      end
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Even-column pixel waits here for its odd-column partner.
  always_ff @(posedge HCLK) begin
    if (accept && !odd_col) a_reg <= s_data;
  end

  // Even rows park their horizontal (L,H) pairs for the odd row below.
  always_ff @(posedge HCLK) begin
    if (accept && odd_col && (state == S_EVEN)) lb[pair_idx] <= lb_wdata;
  end

  // Per-channel horizontal and vertical butterflies.
  always_comb begin
    logic [DATA_W-1:0]       a_c, b_c;
    logic [HW-1:0]           l_c, h_c, l_u, h_u;
    logic signed [OUT_W-1:0] lu_x, lc_x, hu_x, hc_x;
    logic signed [OUT_W-1:0] ll_c, lh_c, hl_c, hh_c;
    lb_wdata = '0;
    ll_n = '0;
    lh_n = '0;
    hl_n = '0;
    hh_n = '0;
    a_c = '0; b_c = '0; l_c = '0; h_c = '0; l_u = '0; h_u = '0;
    lu_x = '0; lc_x = '0; hu_x = '0; hc_x = '0;
    ll_c = '0; lh_c = '0; hl_c = '0; hh_c = '0;
    for (int c = 0; c < CH; c++) begin
      a_c = a_reg[c*DATA_W +: DATA_W];
      b_c = s_data[c*DATA_W +: DATA_W];
      l_c = {1'b0, a_c} + {1'b0, b_c};
      h_c = {1'b0, a_c} - {1'b0, b_c};
      lb_wdata[c*2*HW +: 2*HW] = {h_c, l_c};
      l_u = lb_rdata[c*2*HW +: HW];
      h_u = lb_rdata[c*2*HW + HW +: HW];
      // L is unsigned (zero-extend), H is two's complement (sign-extend).
      lu_x = {2'b00, l_u};
      lc_x = {2'b00, l_c};
      hu_x = {{2{h_u[HW-1]}}, h_u};
      hc_x = {{2{h_c[HW-1]}}, h_c};
      ll_c = lu_x + lc_x;
      lh_c = lu_x - lc_x;
      hl_c = hu_x + hc_x;
      hh_c = hu_x - hc_x;
`ifdef HAAR_NORM_EN
      ll_c = ll_c >>> 2;
      lh_c = lh_c >>> 2;
      hl_c = hl_c >>> 2;
      hh_c = hh_c >>> 2;
`else
      ll_c = ll_c;
`endif
      ll_n[c*OUT_W +: OUT_W] = ll_c;
      lh_n[c*OUT_W +: OUT_W] = lh_c;
      hl_n[c*OUT_W +: OUT_W] = hl_c;
      hh_n[c*OUT_W +: OUT_W] = hh_c;
    end
  end

  // Output register: a fresh load wins over a simultaneous take.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_ll    <= '0;
      m_lh    <= '0;
      m_hl    <= '0;
      m_hh    <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_last  <= col_end && row_end;
      m_ll    <= ll_n;
      m_lh    <= lh_n;
      m_hl    <= hl_n;
      m_hh    <= hh_n;
    end else if (out_take) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

  // One-cycle pulse after the final set of the frame leaves.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) frame_done <= 1'b0;
    else          frame_done <= (state == S_FLUSH) && out_take && m_last;
  end

endmodule

// File: tb/tb_haar_dwt2d_stream.sv
// tb_haar_dwt2d_stream: directed bench for haar_dwt2d_stream.
// dut_a: 4x2 single channel, hand-computed frames, mid-frame reset.
// dut_b: 8x4 three channels, output stall and stray start during odd row.
module tb_haar_dwt2d_stream;

  localparam int OW   = 11;
  localparam int W_B  = 8;
  localparam int H_B  = 4;
  localparam int CH_B = 3;

  logic HCLK = 1'b0;
  logic HRESETn;

  logic            start_a, s_valid_a, s_ready_a, m_valid_a, m_ready_a;
  logic [7:0]      s_data_a;
  logic [OW-1:0]   m_ll_a, m_lh_a, m_hl_a, m_hh_a;
  logic            m_last_a, busy_a, frame_done_a;
  logic [1:0]      dbg_state_a;

  logic                 start_b, s_valid_b, s_ready_b, m_valid_b, m_ready_b;
  logic [CH_B*8-1:0]    s_data_b;
  logic [CH_B*OW-1:0]   m_ll_b, m_lh_b, m_hl_b, m_hh_b;
  logic                 m_last_b, busy_b, frame_done_b;
  logic [1:0]           dbg_state_b;

  logic [4*OW:0]        exp_qa[$];
  logic [4*CH_B*OW:0]   exp_qb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int fd_count_a = 0, fd_count_b = 0, sets_b = 0;
  bit fd_pending_a = 0, fd_pending_b = 0;
  bit arm_stall_b = 0, stall_seen = 0;
  bit held_b = 0;
  logic [4*CH_B*OW:0] held_val_b;

  haar_dwt2d_stream #(.IMG_W(4), .IMG_H(2), .DATA_W(8), .CH(1)) dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start_a),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a),
    .m_ll(m_ll_a), .m_lh(m_lh_a), .m_hl(m_hl_a), .m_hh(m_hh_a),
    .m_last(m_last_a), .busy(busy_a), .frame_done(frame_done_a),
    .dbg_state(dbg_state_a)
  );

  haar_dwt2d_stream #(.IMG_W(W_B), .IMG_H(H_B), .DATA_W(8), .CH(CH_B)) dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start_b),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b),
    .m_ll(m_ll_b), .m_lh(m_lh_b), .m_hl(m_hl_b), .m_hh(m_hh_b),
    .m_last(m_last_b), .busy(busy_b), .frame_done(frame_done_b),
    .dbg_state(dbg_state_b)
  );

  // Clock
  always #5 HCLK = ~HCLK;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int norm(input int v);
`ifdef HAAR_NORM_EN
    return v >>> 2;
`else
    return v;
`endif
  endfunction

  function automatic logic [4*OW:0] pack_a(input int ll, input int lh, input int hl, input int hh, input bit last);
    return {OW'(norm(ll)), OW'(norm(lh)), OW'(norm(hl)), OW'(norm(hh)), last};
  endfunction

  function automatic logic [7:0] pixb(input int r, input int c, input int ch);
    return 8'((r * 67 + c * 29 + ch * 101 + 3) % 256);
  endfunction

  // Expected sets for dut_b straight from each 2x2 block.
  task automatic build_exp_b();
    logic [CH_B*OW-1:0] vll, vlh, vhl, vhh;
    int p00, p01, p10, p11;
    for (int br = 0; br < H_B / 2; br++) begin
      for (int k = 0; k < W_B / 2; k++) begin
        for (int ch = 0; ch < CH_B; ch++) begin
          p00 = int'(pixb(2*br,     2*k,     ch));
          p01 = int'(pixb(2*br,     2*k + 1, ch));
          p10 = int'(pixb(2*br + 1, 2*k,     ch));
          p11 = int'(pixb(2*br + 1, 2*k + 1, ch));
          vll[ch*OW +: OW] = OW'(norm(p00 + p01 + p10 + p11));
          vlh[ch*OW +: OW] = OW'(norm((p00 + p01) - (p10 + p11)));
          vhl[ch*OW +: OW] = OW'(norm((p00 - p01) + (p10 - p11)));
          vhh[ch*OW +: OW] = OW'(norm((p00 - p01) - (p10 - p11)));
        end
        exp_qb.push_back({vll, vlh, vhl, vhh, (br == H_B/2 - 1) && (k == W_B/2 - 1)});
      end
    end
  endtask

  // Drivers: called at a falling edge, return at a falling edge.
  task automatic push_a(input logic [7:0] d);
    bit hs = 0;
    int budget = 200;
    s_valid_a = 1'b1;
    s_data_a  = d;
    do begin
      #4;
      hs = s_ready_a;
      @(negedge HCLK);
      budget--;
    end while (!hs && budget > 0);
    s_valid_a = 1'b0;
    if (!hs) check("a_push_timeout", 0, 1);
  endtask

  task automatic push_b(input logic [CH_B*8-1:0] d);
    bit hs = 0;
    int budget = 200;
    s_valid_b = 1'b1;
    s_data_b  = d;
    do begin
      #4;
      hs = s_ready_b;
      @(negedge HCLK);
      budget--;
    end while (!hs && budget > 0);
    s_valid_b = 1'b0;
    if (!hs) check("b_push_timeout", 0, 1);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge HCLK);
    start_a = 1'b0;
  endtask

  task automatic push_frame_a(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                              input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] p5,
                              input logic [7:0] p6, input logic [7:0] p7);
    push_a(p0); push_a(p1); push_a(p2); push_a(p3);
    push_a(p4); push_a(p5); push_a(p6); push_a(p7);
  endtask

  task automatic drain_a(input string tag);
    for (int i = 0; i < 50 && exp_qa.size() != 0; i++) @(negedge HCLK);
    repeat (3) @(negedge HCLK);
    check({tag, "_drain"}, exp_qa.size(), 0);
    check({tag, "_busy_idle"}, busy_a, 0);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_m_valid"}, m_valid_a, 0);
    check({tag, "_m_last"}, m_last_a, 0);
    check({tag, "_frame_done"}, frame_done_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_s_ready"}, s_ready_a, 0);
    check({tag, "_coef"}, {m_ll_a, m_lh_a, m_hl_a, m_hh_a}, 0);
    check({tag, "_state"}, dbg_state_a, 0);
  endtask

  // Scoreboard for dut_a: compare each accepted set against exp_qa.
  initial begin
    logic [4*OW:0] e;
    forever begin
      @(negedge HCLK);
      #4;
      if (frame_done_a) fd_count_a++;
      if (fd_pending_a) begin
        check("a_frame_done_pulse", frame_done_a, 1);
        fd_pending_a = 0;
      end
      if (HRESETn && m_valid_a && m_ready_a) begin
        if (exp_qa.size() == 0) check("a_unexpected_set", 1, 0);
        else begin
          e = exp_qa.pop_front();
          check("a_coef", {m_ll_a, m_lh_a, m_hl_a, m_hh_a}, e[4*OW:1]);
          check("a_last", m_last_a, e[0]);
          if (e[0]) fd_pending_a = 1;
        end
      end
    end
  end

  // Scoreboard for dut_b, including hold-stable checks while stalled.
  initial begin
    logic [4*CH_B*OW:0] e, cur;
    forever begin
      @(negedge HCLK);
      #4;
      cur = {m_ll_b, m_lh_b, m_hl_b, m_hh_b, m_last_b};
      if (frame_done_b) fd_count_b++;
      if (fd_pending_b) begin
        check("b_frame_done_pulse", frame_done_b, 1);
        fd_pending_b = 0;
      end
      if (HRESETn && m_valid_b && !m_ready_b) begin
        check("b_s_ready_stalled", s_ready_b, 0);
        if (held_b) check("b_stable", cur, held_val_b);
        held_b = 1;
        held_val_b = cur;
      end else begin
        held_b = 0;
      end
      if (HRESETn && m_valid_b && m_ready_b) begin
        sets_b++;
        if (exp_qb.size() == 0) check("b_unexpected_set", 1, 0);
        else begin
          e = exp_qb.pop_front();
          check("b_coef", cur[4*CH_B*OW:1], e[4*CH_B*OW:1]);
          check("b_last", m_last_b, e[0]);
          if (e[0]) fd_pending_b = 1;
        end
      end
    end
  end

  // Hold dut_b's output 5 cycles at its first valid set.
  initial begin
    wait (arm_stall_b);
    for (int i = 0; i < 2000 && !m_valid_b; i++) @(negedge HCLK);
    if (m_valid_b) begin
      stall_seen = 1;
      m_ready_b = 1'b0;
      repeat (5) @(negedge HCLK);
      m_ready_b = 1'b1;
    end
  end

  // Main sequence
  initial begin
    logic [CH_B*8-1:0] v;
    HRESETn = 1'b0;
    start_a = 0; s_valid_a = 0; s_data_a = '0; m_ready_a = 1'b1;
    start_b = 0; s_valid_b = 0; s_data_b = '0; m_ready_b = 1'b1;
    repeat (3) @(negedge HCLK);
    check_reset_a("reset");
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Reference frame
    exp_qa.push_back(pack_a(50, 10, -20, 0, 1'b0));
    exp_qa.push_back(pack_a(130, 10, -20, 0, 1'b1));
    pulse_start_a();
    check("a_busy_after_start", busy_a, 1);
    push_frame_a(10, 20, 30, 40, 5, 15, 25, 35);
    drain_a("f1");

    // Saturated frame
    exp_qa.push_back(pack_a(1020, 0, 0, 0, 1'b0));
    exp_qa.push_back(pack_a(1020, 0, 0, 0, 1'b1));
    pulse_start_a();
    push_frame_a(255, 255, 255, 255, 255, 255, 255, 255);
    drain_a("f255");

    // Reset in the middle of the odd row with a set held at the output
    m_ready_a = 1'b0;
    pulse_start_a();
    push_a(10); push_a(20); push_a(30); push_a(40); push_a(5); push_a(15);
    check("a_pre_rst_valid", m_valid_a, 1);
    check("a_pre_rst_ll", m_ll_a, OW'(norm(50)));
    #2;
    HRESETn = 1'b0;
    #1;
    check_reset_a("midrst");
    @(negedge HCLK);
    HRESETn = 1'b1;
    m_ready_a = 1'b1;
    exp_qa.delete();
    @(negedge HCLK);

    exp_qa.push_back(pack_a(50, 10, -20, 0, 1'b0));
    exp_qa.push_back(pack_a(130, 10, -20, 0, 1'b1));
    pulse_start_a();
    push_frame_a(10, 20, 30, 40, 5, 15, 25, 35);
    drain_a("f_after_rst");
    check("a_frame_done_count", fd_count_a, 3);

    // Three-channel frame with a stall and a stray start in the odd row
    build_exp_b();
    arm_stall_b = 1;
    start_b = 1'b1;
    @(negedge HCLK);
    start_b = 1'b0;
    for (int r = 0; r < H_B; r++) begin
      for (int c = 0; c < W_B; c++) begin
        for (int ch = 0; ch < CH_B; ch++) v[ch*8 +: 8] = pixb(r, c, ch);
        if (r == 1 && c == 3) start_b = 1'b1;
        push_b(v);
        start_b = 1'b0;
      end
    end
    for (int i = 0; i < 60 && exp_qb.size() != 0; i++) @(negedge HCLK);
    repeat (3) @(negedge HCLK);
    check("b_drain", exp_qb.size(), 0);
    check("b_set_count", sets_b, W_B * H_B / 4);
    check("b_frame_done_count", fd_count_b, 1);
    check("b_stall_seen", stall_seen, 1);
    check("b_busy_idle", busy_b, 0);
    check("b_state_idle", dbg_state_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
